// File: rtl/load_store_unit.sv
// Load/store unit: byte-address requests to a word-addressed memory,
// with sub-word loads and read-modify-write sub-word stores.
module load_store_unit #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       load_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    DONE
  } state_t;

  state_t state, state_nx;

  logic              we_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [1:0]        lane_q;
  logic              bad_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;
  logic [31:0]       load_q;

  logic        bad;
  logic [4:0]  shamt;
  logic [31:0] lane_word;
  logic [31:0] ext_val;
  logic [31:0] mask;
  logic [31:0] merged;
  logic        rd;
  logic        wr;
  logic [31:0] wdata_c;
  logic        unused;

  assign unused = ^{cpu_addr[31:ADDR_W+2]};

  assign bad = (size == 2'b11)
             | ((size == 2'b01) & cpu_addr[0])
             | ((size == 2'b10) & (|cpu_addr[1:0]));

  // Halfwords are aligned when accepted, so a byte-lane shift serves both.
  assign shamt     = {lane_q, 3'b000};
  assign lane_word = mem_rdata >> shamt;

  always_comb begin
    ext_val = lane_word;
    case (size_q)
      2'b00:   ext_val = {{24{sext_q & lane_word[7]}}, lane_word[7:0]};
      2'b01:   ext_val = {{16{sext_q & lane_word[15]}}, lane_word[15:0]};
      default: ext_val = lane_word;
    endcase
  end

  assign mask   = ((size_q == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff) << shamt;
  assign merged = (merge_q & ~mask) | ((wdata_q << shamt) & mask);

  always_comb begin
    state_nx = state;
    rd       = 1'b0;
    wr       = 1'b0;
    wdata_c  = 32'h0;
    case (state)
      IDLE: begin
        if (req) state_nx = ACCESS;
      end
      ACCESS: begin
        state_nx = DONE;
        if (!bad_q) begin
          if (!we_q) begin
            rd = 1'b1;
          end else if (size_q == 2'b10) begin
            wr      = 1'b1;
            wdata_c = wdata_q;
          end else begin
            rd       = 1'b1;
            state_nx = WRITE;
          end
        end
      end
      WRITE: begin
        wr       = 1'b1;
        wdata_c  = merged;
        state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      lane_q  <= 2'b00;
      bad_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      merge_q <= 32'h0;
      load_q  <= 32'h0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        we_q    <= we;
        size_q  <= size;
        sext_q  <= sign_ext;
        lane_q  <= cpu_addr[1:0];
        bad_q   <= bad;
        addr_q  <= cpu_addr[ADDR_W+1:2];
        wdata_q <= cpu_wdata;
      end
      if (state == ACCESS && !bad_q && !we_q) load_q <= ext_val;
      if (state == ACCESS && we_q) merge_q <= mem_rdata;
    end
  end

  // Strobes are masked by reset so an aborted write never commits.
  assign mem_rd    = rd & ~rst;
  assign mem_wr    = wr & ~rst;
  assign mem_wdata = mem_wr ? wdata_c : 32'h0;
  assign mem_addr  = addr_q;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = (state == DONE) & bad_q;
  assign load_data = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: memory model, cycle-level request model
// compared every cycle, plus hand-computed memory/load-data checks.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic        busy, done, err;
  logic [31:0] load_data;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [0:255] = '{default: 32'h0};

  int n_chk = 0;
  int n_fail = 0;
  logic en = 1'b0;

  load_store_unit #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .busy(busy), .done(done), .err(err), .load_data(load_data),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_bad(input logic [1:0] sz, input logic [1:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a != 2'd0);
  endfunction

  function automatic logic [31:0] ext_load(input logic [31:0] w,
      input logic [1:0] sz, input logic [1:0] a, input logic sx);
    logic [31:0] v;
    v = w >> (8 * a);
    if (sz == 2'd0) begin
      v = v & 32'hff;
      if (sx && v >= 32'd128) v = v | 32'hffffff00;
    end else if (sz == 2'd1) begin
      v = v & 32'hffff;
      if (sx && v >= 32'd32768) v = v | 32'hffff0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w,
      input logic [1:0] sz, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] m;
    m = ((sz == 2'd0) ? 32'hff : 32'hffff) << (8 * a);
    return (w & ~m) | ((d << (8 * a)) & m);
  endfunction

  // Request model: cycles elapsed since acceptance.
  int          m_phase = 0;
  logic        m_we = 1'b0;
  logic [1:0]  m_sz = 2'd0;
  logic        m_sx = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_wd = 32'h0;
  logic        m_err = 1'b0;
  logic [31:0] exp_ld = 32'h0;

  function automatic int m_len();
    return (m_we && m_sz != 2'd2 && !m_err) ? 3 : 2;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      exp_ld  <= 32'h0;
    end else if (m_phase == 0) begin
      if (req) begin
        m_phase <= 1;
        m_we    <= we;
        m_sz    <= size;
        m_sx    <= sign_ext;
        m_addr  <= cpu_addr;
        m_wd    <= cpu_wdata;
        m_err   <= is_bad(size, cpu_addr[1:0]);
      end
    end else begin
      m_phase <= (m_phase == m_len()) ? 0 : m_phase + 1;
      if (m_phase == 1 && !m_we && !m_err)
        exp_ld <= ext_load(mem[m_addr[9:2]], m_sz, m_addr[1:0], m_sx);
    end
  end

  always @(negedge clk) begin
    if (en) begin
      logic e_done, e_rd, e_wr;
      logic [31:0] e_wd;
      e_done = (m_phase != 0) && (m_phase == m_len());
      e_rd = !rst && m_phase == 1 && !m_err && (!m_we || m_sz != 2'd2);
      e_wr = !rst && !m_err && m_we &&
             ((m_sz == 2'd2 && m_phase == 1) || (m_sz != 2'd2 && m_phase == 2));
      e_wd = 32'h0;
      if (e_wr)
        e_wd = (m_sz == 2'd2) ? m_wd
             : merge(mem[m_addr[9:2]], m_sz, m_addr[1:0], m_wd);
      chk("busy", {31'b0, busy}, {31'b0, m_phase != 0});
      chk("done", {31'b0, done}, {31'b0, e_done});
      chk("err", {31'b0, err}, {31'b0, e_done && m_err});
      chk("mem_rd", {31'b0, mem_rd}, {31'b0, e_rd});
      chk("mem_wr", {31'b0, mem_wr}, {31'b0, e_wr});
      chk("mem_wdata", mem_wdata, e_wd);
      chk("load_data", load_data, exp_ld);
      if (e_rd || e_wr)
        chk("mem_addr", {16'b0, mem_addr}, {16'b0, m_addr[17:2]});
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (!busy) return;
    end
    chk("timeout_busy", {31'b0, busy}, 32'h0);
  endtask

  task automatic op(input logic w, input logic [1:0] sz, input logic sx,
                    input logic [31:0] a, input logic [31:0] d);
    we = w; size = sz; sign_ext = sx; cpu_addr = a; cpu_wdata = d;
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    wait_idle();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b1;
    chk("reset_load_data", load_data, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);

    op(1, 2'd2, 0, 32'h10, 32'hdeadbeef);
    chk("sw_mem4", mem[4], 32'hdeadbeef);
    op(0, 2'd2, 0, 32'h10, 32'h0);
    chk("lw_0x10", load_data, 32'hdeadbeef);

    op(1, 2'd2, 0, 32'h10, 32'h11223344);
    op(1, 2'd0, 0, 32'h12, 32'h123456aa);
    chk("sb_0x12", mem[4], 32'h11aa3344);

    op(1, 2'd2, 0, 32'h10, 32'h80ff7f01);
    op(0, 2'd0, 1, 32'h13, 32'h0);
    chk("lb_0x13", load_data, 32'hffffff80);
    op(0, 2'd0, 0, 32'h13, 32'h0);
    chk("lbu_0x13", load_data, 32'h00000080);
    op(0, 2'd1, 1, 32'h12, 32'h0);
    chk("lh_0x12", load_data, 32'hffff80ff);
    op(0, 2'd1, 0, 32'h10, 32'h0);
    chk("lhu_0x10", load_data, 32'h00007f01);

    op(0, 2'd1, 1, 32'h11, 32'h0);
    chk("lh_mis_keep", load_data, 32'h00007f01);
    op(1, 2'd2, 0, 32'h12, 32'h55555555);
    chk("sw_mis_mem", mem[4], 32'h80ff7f01);
    op(0, 2'd3, 0, 32'h10, 32'h0);
    chk("size3_keep", load_data, 32'h00007f01);

    op(1, 2'd1, 0, 32'h12, 32'hffffbeef);
    chk("sh_0x12", mem[4], 32'hbeef7f01);
    op(1, 2'd0, 0, 32'h10, 32'h00000077);
    chk("sb_0x10", mem[4], 32'hbeef7f77);

    // Store aborted by reset in its write cycle; extra req while busy.
    op(1, 2'd2, 0, 32'h14, 32'h12345678);
    we = 1; size = 2'd1; sign_ext = 0; cpu_addr = 32'h16; cpu_wdata = 32'hcafe;
    req = 1'b1;
    @(posedge clk);
    #1;
    cpu_addr = 32'h18; size = 2'd2;
    @(posedge clk);
    #1;
    req = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_mem5", mem[5], 32'h12345678);
    chk("abort_mem6", mem[6], 32'h0);
    chk("abort_idle", {31'b0, busy}, 32'h0);
    chk("abort_ld", load_data, 32'h0);

    // Request held through the done cycle is not queued.
    we = 0; size = 2'd2; sign_ext = 0; cpu_addr = 32'h14;
    req = 1'b1;
    @(posedge clk);
    #1;
    we = 1; cpu_addr = 32'h18; cpu_wdata = 32'h99999999;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    req = 1'b0;
    chk("noqueue_idle", {31'b0, busy}, 32'h0);
    chk("lw_0x14", load_data, 32'h12345678);
    repeat (2) @(posedge clk);
    #1;
    chk("noqueue_mem6", mem[6], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

- Pipeline-side initiator for the word-addressed data memory: accepts one load/store request at a time from the MEM stage and converts byte addresses to word addresses.
- Issues `mem_rd`/`mem_wr` strobes and returns aligned, extended load data.
- Implements byte/halfword loads (signed/unsigned) and byte/halfword stores; sub-word stores use a read-modify-write over two memory cycles.
- Holds the pipeline with `busy` until `done`.

## Interface
Parameters:
- ADDR_W, 16, memory word-address width (`mem_addr`).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  1  request strobe; sampled only when `busy`=0.
- we  in  1  1=store, 0=load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- sign_ext  in  1  loads only: 1 sign-extend, 0 zero-extend.
- cpu_addr  in  32  byte address; bits [ADDR_W+1:2] form the word address, upper bits ignored.
- cpu_wdata  in  32  store data; byte/half taken from the low bits.
- busy  out  1  request in flight.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with `done`; request was misaligned or reserved size.
- load_data  out  32  extended load result, updated at load `done`, held until the next successful load.
- mem_addr  out  ADDR_W  word address to memory.
- mem_rd  out  1  read strobe.
- mem_wr  out  1  write strobe; memory commits `mem_wdata` at the next rising edge.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  combinational read data for `mem_addr`.

## Operation
- Lane mapping is little-endian: byte lane k = `cpu_addr[1:0]` = k occupies bits [8k+7:8k]. Halfword lane h = `cpu_addr[1]` occupies bits [16h+15:16h].
- Alignment:
  - Halfword requires `addr[0]`=0.
  - Word requires `addr[1:0]`=0.
  - size=11 is always an error.
- FSM states: IDLE, ACCESS, WRITE, DONE.
- IDLE:
  - `busy`=0.
  - On `req`=1: latch we/size/sign_ext/addr/wdata, then go to ACCESS.
- ACCESS:
  - `mem_addr` = latched word address.
  - Misaligned/reserved: no strobes; set err; go to DONE.
  - Load: `mem_rd`=1; select lane from `mem_rdata`; extend to 32 bits; register into `load_data`; go to DONE.
  - Word store: `mem_wr`=1, `mem_wdata`=latched data; go to DONE.
  - Byte/half store: `mem_rd`=1; capture `mem_rdata` into a merge buffer; go to WRITE.
- WRITE:
  - `mem_wr`=1.
  - `mem_wdata` = merge buffer with the target lane replaced by the low byte/half of latched data; all other lanes unchanged.
  - Go to DONE.
- DONE:
  - `done`=1 for one cycle, `err` as computed; go to IDLE.
- `busy`=1 in ACCESS, WRITE and DONE.
- `req` while `busy`=1 is ignored (not queued).
- `mem_rd` and `mem_wr` are never both 1. Both are gated by `~rst`, so no write commits on a reset edge.
- `mem_wdata` = 0 whenever `mem_wr`=0.

## Timing
- Reset values:
  - state IDLE.
  - `busy`, `done`, `err`, `mem_rd`, `mem_wr` = 0.
  - `load_data`, `mem_addr`, `mem_wdata`, merge buffer = 0.
- Latency, with `req` accepted at edge N:
  - Load, word store, or error: `done` high during cycle N+2.
  - Byte/half store: `done` high during cycle N+3.
- Next request is accepted the cycle after `done` (IDLE). Minimum issue interval is 3 cycles, or 4 for sub-word stores.
- `load_data` changes only on the edge entering DONE for a successful load. Errored loads leave it unchanged.
- Reset in any state returns to IDLE next edge.
  - If reset is asserted during WRITE, the memory word is unmodified.
  - No `done` is produced for the aborted request.

## Test plan
- Word store `cpu_addr`=0x10, data 0xDEADBEEF, then word load 0x10 → memory word 4 = 0xDEADBEEF; `load_data`=0xDEADBEEF; `done` at N+2; `err`=0.
- Byte store 0xAA to 0x12 over word 4 = 0x11223344 → `mem_rd` in ACCESS, `mem_wr` in WRITE with 0x11AA3344; `done` at N+3.
- Word 4 = 0x80FF7F01:
  - lb 0x13 (sign) → 0xFFFFFF80.
  - lbu 0x13 → 0x00000080.
  - lh 0x12 → 0xFFFF80FF.
  - lhu 0x10 → 0x00007F01.
- Misaligned cases: lh at 0x11, sw at 0x12, size=11 → no `mem_rd`/`mem_wr`; `done`+`err` at N+2; `load_data` unchanged.
- Assert `rst` during WRITE of an sh → `mem_wr` low that cycle, memory word unchanged, state IDLE, no `done`. A second `req` pulsed while `busy` is ignored.
